// File: rtl/conv32b_to_2b_core.sv
// conv32Bto2B user core: 32-bit words out as 16 two-bit symbol items.
// Define CONV2B_QPSK_MAP_EN to emit QPSK I/Q pairs instead of raw symbols.
module conv32b_to_2b_core #(
  parameter int unsigned       OUT_PKT_ITEMS = 256,
  parameter logic signed [15:0] QPSK_AMP     = 16'sd11585
) (
  input  logic        axis_data_clk,
  input  logic        axis_data_rst,
  input  logic        s_ctrlport_req_wr,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  input  logic [31:0] s_ctrlport_req_data,
  output logic        s_ctrlport_resp_ack,
  output logic [31:0] s_ctrlport_resp_data,
  input  logic [31:0] s_in_axis_tdata,
  input  logic        s_in_axis_tkeep,
  input  logic        s_in_axis_tlast,
  input  logic        s_in_axis_tvalid,
  output logic        s_in_axis_tready,
  input  logic [63:0] s_in_axis_ttimestamp,
  input  logic        s_in_axis_thas_time,
  input  logic [15:0] s_in_axis_tlength,
  input  logic        s_in_axis_teov,
  input  logic        s_in_axis_teob,
  output logic [31:0] m_out_axis_tdata,
  output logic        m_out_axis_tkeep,
  output logic        m_out_axis_tlast,
  output logic        m_out_axis_tvalid,
  input  logic        m_out_axis_tready,
  output logic [63:0] m_out_axis_ttimestamp,
  output logic        m_out_axis_thas_time,
  output logic        m_out_axis_teov,
  output logic        m_out_axis_teob
);

  localparam logic [15:0] PKT_M1 = 16'(OUT_PKT_ITEMS - 1);
  localparam logic [31:0] PKT_W  = 32'(OUT_PKT_ITEMS);
  localparam logic [19:0] A_CTRL = 20'h00;
  localparam logic [19:0] A_SCNT = 20'h04;
  localparam logic [19:0] A_PKT  = 20'h08;

  logic        vld_q;
  logic [31:0] word_q;
  logic [3:0]  sidx_q;
  logic        last_q;
  logic        msb_q;
  logic        ht_q;
  logic        eov_q;
  logic        eob_q;
  logic [63:0] ts_q;
  logic [15:0] ocnt_q;
  logic        first_q;
  logic        ctrl_q;
  logic [31:0] scnt_q;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic        hs;
  logic        fin;
  logic        tlast_c;
  logic        acc;
  logic        eoseg;
  logic [16:0] rem_end;
  logic [1:0]  sym;
  logic [31:0] data_c;
  logic [31:0] rdata_d;

  logic unused_ok;
  assign unused_ok = ^{s_in_axis_tkeep, s_in_axis_tlength,
                       s_ctrlport_req_data[31:1]};

  assign hs      = vld_q & m_out_axis_tready;
  assign fin     = (sidx_q == 4'hF);
  assign tlast_c = (fin & last_q) | (ocnt_q == PKT_M1);
  assign acc     = s_in_axis_tvalid & s_in_axis_tready;

  // The rest of this word fits in the current packet, so it closes the input packet.
  assign rem_end = {1'b0, ocnt_q} + {13'b0, ~sidx_q};
  assign eoseg   = last_q & (rem_end <= {1'b0, PKT_M1});

  always_comb begin
    sym = 2'b00;
    if (msb_q) sym = word_q[(5'd30 - {sidx_q, 1'b0}) +: 2];
    else       sym = word_q[{sidx_q, 1'b0} +: 2];
  end

`ifdef CONV2B_QPSK_MAP_EN
  localparam logic [15:0] AMP_P = QPSK_AMP;
  localparam logic [15:0] AMP_N = 16'(-QPSK_AMP);
  assign data_c = {sym[1] ? AMP_N : AMP_P, sym[0] ? AMP_N : AMP_P};
`else
  assign data_c = {30'b0, sym};
`endif

  assign s_in_axis_tready      = ~vld_q | (hs & fin);
  assign m_out_axis_tvalid     = vld_q;
  assign m_out_axis_tdata      = vld_q ? data_c : 32'h0;
  assign m_out_axis_tkeep      = 1'b1;
  assign m_out_axis_tlast      = vld_q & tlast_c;
  assign m_out_axis_ttimestamp = ts_q;
  assign m_out_axis_thas_time  = vld_q & first_q & ht_q;
  assign m_out_axis_teov       = vld_q & eoseg & eov_q;
  assign m_out_axis_teob       = vld_q & eoseg & eob_q;
  assign s_ctrlport_resp_ack   = ack_q;
  assign s_ctrlport_resp_data  = rdata_q;

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      vld_q   <= 1'b0;
      word_q  <= '0;
      sidx_q  <= '0;
      last_q  <= 1'b0;
      msb_q   <= 1'b0;
      ht_q    <= 1'b0;
      eov_q   <= 1'b0;
      eob_q   <= 1'b0;
      ts_q    <= '0;
      ocnt_q  <= '0;
      first_q <= 1'b1;
    end else begin
      if (hs) begin
        sidx_q <= sidx_q + 4'd1;
        if (tlast_c) begin
          ocnt_q  <= '0;
          first_q <= fin & last_q;
        end else begin
          ocnt_q <= ocnt_q + 16'd1;
        end
      end
      if (acc) begin
        vld_q  <= 1'b1;
        word_q <= s_in_axis_tdata;
        last_q <= s_in_axis_tlast;
        msb_q  <= ctrl_q;
        ht_q   <= s_in_axis_thas_time;
        ts_q   <= s_in_axis_ttimestamp;
        eov_q  <= s_in_axis_teov;
        eob_q  <= s_in_axis_teob;
      end else if (hs & fin) begin
        vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_d = 32'h0;
    unique case (1'b1)
      s_ctrlport_req_addr == A_CTRL: rdata_d = {31'b0, ctrl_q};
      s_ctrlport_req_addr == A_SCNT: rdata_d = scnt_q;
      s_ctrlport_req_addr == A_PKT:  rdata_d = PKT_W;
      default:                       rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      ctrl_q  <= 1'b1;
      scnt_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= s_ctrlport_req_wr | s_ctrlport_req_rd;
      rdata_q <= s_ctrlport_req_rd ? rdata_d : 32'h0;
      if (s_ctrlport_req_wr && s_ctrlport_req_addr == A_CTRL)
        ctrl_q <= s_ctrlport_req_data[0];
      // A clear write wins over a same-cycle handshake.
      if (s_ctrlport_req_wr && s_ctrlport_req_addr == A_SCNT)
        scnt_q <= '0;
      else if (hs)
        scnt_q <= scnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_conv32b_to_2b_core.sv
// Scoreboard bench for conv32b_to_2b_core.
// Stimulus pushes expected items; a negedge monitor pops and compares.
module tb_conv32b_to_2b_core;

  localparam int PKT = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_wr = 1'b0, c_rd = 1'b0;
  logic [19:0] c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_ack;
  logic [31:0] c_rdata;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0, i_valid = 1'b0, i_ready;
  logic [63:0] i_ts = '0;
  logic        i_ht = 1'b0, i_eov = 1'b0, i_eob = 1'b0;
  logic [31:0] o_data;
  logic        o_keep, o_last, o_valid;
  logic        o_ready = 1'b1;
  logic [63:0] o_ts;
  logic        o_ht, o_eov, o_eob;

  always #5 clk = ~clk;

  conv32b_to_2b_core #(.OUT_PKT_ITEMS(PKT)) dut (
    .axis_data_clk(clk), .axis_data_rst(rst),
    .s_ctrlport_req_wr(c_wr), .s_ctrlport_req_rd(c_rd),
    .s_ctrlport_req_addr(c_addr), .s_ctrlport_req_data(c_wdata),
    .s_ctrlport_resp_ack(c_ack), .s_ctrlport_resp_data(c_rdata),
    .s_in_axis_tdata(i_data), .s_in_axis_tkeep(1'b1),
    .s_in_axis_tlast(i_last), .s_in_axis_tvalid(i_valid),
    .s_in_axis_tready(i_ready), .s_in_axis_ttimestamp(i_ts),
    .s_in_axis_thas_time(i_ht), .s_in_axis_tlength(16'd0),
    .s_in_axis_teov(i_eov), .s_in_axis_teob(i_eob),
    .m_out_axis_tdata(o_data), .m_out_axis_tkeep(o_keep),
    .m_out_axis_tlast(o_last), .m_out_axis_tvalid(o_valid),
    .m_out_axis_tready(o_ready), .m_out_axis_ttimestamp(o_ts),
    .m_out_axis_thas_time(o_ht), .m_out_axis_teov(o_eov),
    .m_out_axis_teob(o_eob)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        ht;
    logic [63:0] ts;
    logic        eov;
    logic        eob;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  bit   mon_en = 1'b1;
  bit   rand_en = 1'b0;
  int   m_ocnt = 0;
  bit   m_first = 1'b1;

  function automatic logic [31:0] mapd(input logic [1:0] s);
`ifdef CONV2B_QPSK_MAP_EN
    mapd = {s[1] ? 16'hD2BF : 16'h2D41, s[0] ? 16'hD2BF : 16'h2D41};
`else
    mapd = {30'b0, s};
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] s, input logic l, input logic ht,
                          input logic [63:0] ts, input logic eov, input logic eob);
    exp_t e;
    e.d = mapd(s); e.l = l; e.ht = ht; e.ts = ts; e.eov = eov; e.eob = eob;
    sbq.push_back(e);
  endtask

  // Reference model used for the long random-stall run.
  task automatic push_word(input logic [31:0] w, input bit msb, input bit last,
                           input bit ht, input logic [63:0] ts);
    logic [1:0] s;
    bit l;
    for (int k = 0; k < 16; k++) begin
      s = msb ? w[31-2*k -: 2] : w[2*k +: 2];
      l = (k == 15 && last) || (m_ocnt == PKT - 1);
      push_exp(s, l, m_first & ht, ts, 1'b0, 1'b0);
      if (l) begin
        m_first = (k == 15) && last;
        m_ocnt = 0;
      end else begin
        m_ocnt++;
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input bit last, input bit ht,
                      input logic [63:0] ts, input bit eov, input bit eob);
    int n = 0;
    @(negedge clk);
    i_data = w; i_last = last; i_ht = ht; i_ts = ts; i_eov = eov; i_eob = eob;
    i_valid = 1'b1;
    while (!i_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || o_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  task automatic reg_op(input bit wr, input logic [19:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm);
    @(posedge clk);
    #1;
    c_wr = wr; c_rd = ~wr; c_addr = a; c_wdata = d;
    @(posedge clk);
    #1;
    c_wr = 1'b0; c_rd = 1'b0;
    chk({nm, "_ack"}, 64'(c_ack), 64'd1);
    if (!wr) chk(nm, 64'(c_rdata), 64'(exp));
  endtask

  // Monitor: compare each handshake beat and check stalled beats stay stable.
  initial begin
    logic        stall;
    logic [31:0] held;
    exp_t e;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (mon_en && stall && o_valid) chk("stall_data", 64'(o_data), 64'(held));
        stall = o_valid & ~o_ready;
        held = o_data;
        if (o_valid && o_ready) begin
          hs_cnt++;
          if (mon_en) begin
            if (sbq.size() == 0) begin
              chk("unexpected_beat", 64'(o_data), 64'hDEAD);
            end else begin
              e = sbq.pop_front();
              chk("beat", {o_data, 26'b0, o_last, o_ht, o_eov, o_eob, 2'b0},
                  {e.d, 26'b0, e.l, e.ht, e.eov, e.eob, 2'b0});
              chk("beat_ts", o_ts, e.ts);
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_en) o_ready = ($urandom_range(0, 1) == 1);
    else         o_ready = 1'b1;
  end

  initial begin
    logic [1:0] pat [4];
    logic [31:0] w;
    int base;
    int n;
    pat[0] = 2'd3; pat[1] = 2'd2; pat[2] = 2'd1; pat[3] = 2'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(o_valid), 64'd0);
    chk("rst_tready", 64'(i_ready), 64'd1);
    chk("rst_ack", 64'(c_ack), 64'd0);
    chk("rst_tkeep", 64'(o_keep), 64'd1);
    chk("rst_outs", {o_data, 28'b0, o_last, o_ht, o_eov, o_eob}, 64'd0);
    reg_op(1'b0, 20'h00, 32'h0, 32'h1, "ctrl_rst");
    reg_op(1'b0, 20'h04, 32'h0, 32'h0, "scnt_rst");
    reg_op(1'b0, 20'h08, 32'h0, 32'd24, "pkt_items");
    reg_op(1'b0, 20'h10, 32'h0, 32'h0, "unmapped");

    // MSB-first 0xE4E4E4E4: 3,2,1,0 repeating, tlast on item 16.
    for (int k = 0; k < 16; k++) push_exp(pat[k % 4], k == 15, 1'b0, 64'h0, 1'b0, 1'b0);
    send(32'hE4E4E4E4, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_valid", 64'(o_valid), 64'd1);
    drain();

    // LSB-first 0x1B: 3,2,1,0 then twelve zeros.
    reg_op(1'b1, 20'h00, 32'h0, 32'h0, "ctrl_wr0");
    for (int k = 0; k < 16; k++)
      push_exp(k < 4 ? pat[k] : 2'd0, k == 15, 1'b0, 64'h0, 1'b0, 1'b0);
    send(32'h0000001B, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    drain();
    reg_op(1'b1, 20'h00, 32'h1, 32'h0, "ctrl_wr1");

    // Two-word packet split 24 + 8 with timestamp on the first sub-packet.
    for (int k = 0; k < 16; k++) push_exp(pat[k % 4], 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)  push_exp(pat[k % 4], k == 7, 1'b1, 64'h1000, 1'b0, 1'b0);
    for (int k = 8; k < 16; k++) push_exp(pat[k % 4], k == 15, 1'b0, 64'h1000, 1'b0, 1'b1);
    send(32'hE4E4E4E4, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b1);
    send(32'hE4E4E4E4, 1'b1, 1'b1, 64'h1000, 1'b0, 1'b1);
    drain();

    // 100 words under random back-pressure.
    reg_op(1'b1, 20'h04, 32'h0, 32'h0, "scnt_clr0");
    m_ocnt = 0;
    m_first = 1'b1;
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = $urandom();
      push_word(w, 1'b1, (i % 10) == 9, 1'b0, 64'h0);
      send(w, (i % 10) == 9, 1'b0, 64'h0, 1'b0, 1'b0);
    end
    drain();
    rand_en = 1'b0;
    reg_op(1'b0, 20'h04, 32'h0, 32'd1600, "scnt_1600");
    reg_op(1'b1, 20'h04, 32'h0, 32'h0, "scnt_clr");
    reg_op(1'b0, 20'h04, 32'h0, 32'h0, "scnt_zero");

    // Reset in the middle of a word.
    mon_en = 1'b0;
    base = hs_cnt;
    send(32'h12345678, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    n = 0;
    while (hs_cnt < base + 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_hs", 64'(hs_cnt - base), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", 64'(o_valid), 64'd0);
    chk("mid_rst_tready", 64'(i_ready), 64'd1);
    mon_en = 1'b1;
    m_ocnt = 0;
    m_first = 1'b1;
    reg_op(1'b0, 20'h04, 32'h0, 32'h0, "scnt_after_rst");
    push_word(32'h9ABCDEF0, 1'b1, 1'b1, 1'b1, 64'h55);
    send(32'h9ABCDEF0, 1'b1, 1'b1, 64'h55, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
